// File: rtl/mc_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_controller_pkg                                                     |
// | Shared encodings and per-state control table for the multicycle      |
// | controller.                                                           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore output table; anything not listed for a state stays 0.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
      S_DECODE:   c.alusrcb = 2'b11;
      S_MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:    c.iord = 1'b1;
      S_MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      S_MEMWR:    begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_EXECUTE:  begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
      S_ALUWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BRANCH:   begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIEXEC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:   c.regwrite = 1'b1;
      S_JUMP:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_controller_aludec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aludec                                                                |
// | Combinational ALU operation decode from aluop and R-type funct.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module aludec
  import mc_controller_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_controller                                                         |
// | Moore FSM controller for a multicycle MIPS-style datapath.            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  state_t cur_state;
  state_t nxt_state;
  ctrl_t  ctrl;

  // op only matters when leaving DECODE or MEMADR.
  function automatic state_t next_state(input state_t s, input logic [5:0] opcode);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:  n = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_RTYPE:     n = S_EXECUTE;
          OP_BEQ:       n = S_BRANCH;
          OP_ADDI:      n = S_ADDIEXEC;
          OP_J:         n = S_JUMP;
          default:      n = S_FETCH;
        endcase
      end
      S_MEMADR:   n = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    n = S_MEMWB;
      S_EXECUTE:  n = S_ALUWB;
      S_ADDIEXEC: n = S_ADDIWB;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

  assign nxt_state = next_state(cur_state, op);

  // Outputs are registered alongside the state so they change only on the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_FETCH;
      ctrl      <= state_ctrl(S_FETCH);
    end else begin
      cur_state <= nxt_state;
      ctrl      <= state_ctrl(nxt_state);
    end
  end

  aludec u_aludec (
    .funct      (funct),
    .aluop      (ctrl.aluop),
    .alucontrol (alucontrol)
  );

  assign pcen     = ctrl.pcwrite | (ctrl.branch & zero);
  assign irwrite  = ctrl.irwrite;
  assign regwrite = ctrl.regwrite;
  assign memwrite = ctrl.memwrite;
  assign alusrca  = ctrl.alusrca;
  assign iord     = ctrl.iord;
  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign state    = cur_state;

endmodule
`default_nettype wire
